// File: rtl/sram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_arbiter_if
// Bundles every bus signal around the SRAM command-port arbiter: the two
// requester ports (m0_*, m1_*), the shared controller port (s_*) and the
// sticky orphan-return flag.
//   modport slave  : arbiter view (serves m0/m1, drives the controller port)
//   modport master : environment view (requesters plus controller model)
// Parameters: ADDR_W word-address width, DATA_W data width.
// ---------------------------------------------------------------------------
interface sram_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  // requester 0
  logic [ADDR_W-1:0] m0_address;
  logic [1:0]        m0_byteenable;
  logic              m0_read;
  logic              m0_write;
  logic [DATA_W-1:0] m0_writedata;
  logic              m0_waitrequest;
  logic [DATA_W-1:0] m0_readdata;
  logic              m0_readdatavalid;
  // requester 1
  logic [ADDR_W-1:0] m1_address;
  logic [1:0]        m1_byteenable;
  logic              m1_read;
  logic              m1_write;
  logic [DATA_W-1:0] m1_writedata;
  logic              m1_waitrequest;
  logic [DATA_W-1:0] m1_readdata;
  logic              m1_readdatavalid;
  // controller command port
  logic [ADDR_W-1:0] s_address;
  logic [1:0]        s_byteenable;
  logic              s_read;
  logic              s_write;
  logic [DATA_W-1:0] s_writedata;
  logic [DATA_W-1:0] s_readdata;
  logic              s_readdatavalid;
  // status
  logic              err_orphan;

  modport slave (
    input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    output m0_waitrequest, m0_readdata, m0_readdatavalid,
    input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    output m1_waitrequest, m1_readdata, m1_readdatavalid,
    output s_address, s_byteenable, s_read, s_write, s_writedata,
    input  s_readdata, s_readdatavalid,
    output err_orphan
  );

  modport master (
    output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
    input  m0_waitrequest, m0_readdata, m0_readdatavalid,
    output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
    input  m1_waitrequest, m1_readdata, m1_readdatavalid,
    input  s_address, s_byteenable, s_read, s_write, s_writedata,
    output s_readdata, s_readdatavalid,
    input  err_orphan
  );
endinterface

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter
// Shares one SRAM controller command port between two requesters. Ownership
// is granted in runs of up to HOLD_MAX accepted commands and alternates when
// both request. Accepted reads push the issuing master's ID into an in-order
// FIFO so returning read data is steered back with no added latency.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high reset
//   bus    sram_arbiter_if.slave: m0_*/m1_* requester ports, s_* controller
//          port, err_orphan (sticky: read data returned with no read pending)
// Parameters: HOLD_MAX run length, MAX_OUTSTANDING ID FIFO depth (pow2, >=2).
// ---------------------------------------------------------------------------
module sram_arbiter #(
  parameter int HOLD_MAX        = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam int RUN_W = $clog2(HOLD_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_LAST  = RUN_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             r_last_owner, w_last_owner_nxt;
  logic [RUN_W-1:0] r_cnt, w_cnt_nxt;

  logic             r_id_fifo [MAX_OUTSTANDING];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_err_orphan;

  logic w_req0, w_req1;
  logic w_owned, w_owner;
  logic w_own_rd, w_own_wr, w_own_req, w_other_req;
  logic w_stall, w_accept, w_push, w_pop, w_empty, w_head;

  assign w_req0 = bus.m0_read | bus.m0_write;
  assign w_req1 = bus.m1_read | bus.m1_write;

  // While reset is held every grant is suppressed combinationally, whatever
  // state the register still holds.
  assign w_owned = (r_state != ST_IDLE) && !reset;
  assign w_owner = (r_state == ST_OWN1);

  // Read+write together is a protocol error: it is treated as a write only.
  assign w_own_wr    = w_owner ? bus.m1_write : bus.m0_write;
  assign w_own_rd    = (w_owner ? bus.m1_read : bus.m0_read) & ~w_own_wr;
  assign w_own_req   = w_own_rd | w_own_wr;
  assign w_other_req = w_owner ? w_req0 : w_req1;

  // Full FIFO stalls reads even if an entry is popped in the same cycle;
  // this keeps the stall off the s_readdatavalid timing path.
  assign w_stall  = w_owned && w_own_rd && (r_count == FIFO_FULL);
  assign w_accept = w_owned && w_own_req && !w_stall;
  assign w_push   = w_accept && w_own_rd;

  assign w_empty = (r_count == '0);
  assign w_head  = r_id_fifo[r_rd_ptr];
  assign w_pop   = bus.s_readdatavalid && !w_empty && !reset;

  // Command path
  assign bus.m0_waitrequest = !(w_owned && !w_owner) || w_stall;
  assign bus.m1_waitrequest = !(w_owned &&  w_owner) || w_stall;
  assign bus.s_read         = w_accept && w_own_rd;
  assign bus.s_write        = w_accept && w_own_wr;
  assign bus.s_address      = w_owner ? bus.m1_address    : bus.m0_address;
  assign bus.s_byteenable   = w_owner ? bus.m1_byteenable : bus.m0_byteenable;
  assign bus.s_writedata    = w_owner ? bus.m1_writedata  : bus.m0_writedata;

  // Return path: data is broadcast, the valid is steered by the FIFO head.
  assign bus.m0_readdata      = bus.s_readdata;
  assign bus.m1_readdata      = bus.s_readdata;
  assign bus.m0_readdatavalid = w_pop && !w_head;
  assign bus.m1_readdatavalid = w_pop &&  w_head;
  assign bus.err_orphan       = r_err_orphan;

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves it unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    w_cnt_nxt        = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req0 && w_req1) w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
        else if (w_req0)      w_state_nxt = ST_OWN0;
        else if (w_req1)      w_state_nxt = ST_OWN1;
      end
      ST_OWN0, ST_OWN1: begin
        if (!w_own_req) begin
          // Owner let go: hand straight over without a bubble, or go idle.
          if (w_other_req) w_state_nxt = w_owner ? ST_OWN0 : ST_OWN1;
          else             w_state_nxt = ST_IDLE;
          w_cnt_nxt        = '0;
          w_last_owner_nxt = w_owner;
        end else if (w_accept) begin
          if (r_cnt == RUN_LAST) begin
            // Run exhausted: yield only if the other side is waiting.
            w_cnt_nxt = '0;
            if (w_other_req) begin
              w_state_nxt      = w_owner ? ST_OWN0 : ST_OWN1;
              w_last_owner_nxt = w_owner;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_cnt        <= w_cnt_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      if (bus.s_readdatavalid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  // NOTE: the ID storage is deliberately not reset; entries are only ever
  // read below the occupancy count, which is reset.
  always_ff @(posedge clk) begin
    if (w_push) r_id_fifo[r_wr_ptr] <= w_owner;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_arbiter
// Drives both requesters from command queues (held while waitrequest), models
// the controller as an in-order read responder with configurable latency,
// and compares every DUT output each cycle against a behavioural model built
// from ownership rules and a queue of outstanding read IDs. Directed scenarios
// add hand-computed expectations on top of the model.
// ---------------------------------------------------------------------------
module tb_sram_arbiter;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int HOLD_MAX = 4;
  localparam int MAXO     = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(.HOLD_MAX(HOLD_MAX), .MAX_OUTSTANDING(MAXO)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] data;
    int          gap;
  } cmd_t;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // stimulus state
  cmd_t mq0[$];
  cmd_t mq1[$];
  cmd_t cur[2];
  bit   cur_v[2];
  bit   acc_seen[2];

  // controller responder
  int rq[$];
  int last_due = 0;
  int lat = 2;
  bit lat_rand = 1'b0;
  bit inject_stray = 1'b0;

  // observation logs
  int acc_m[$], acc_c[$], acc_addr[$], acc_be[$], acc_data[$], acc_w[$];
  int rdv_m[$], rdv_c[$];
  int first_req_c = -1;

  // model state
  int m_own = -1;
  int m_last = 1;
  int m_run = 0;
  int m_idq[$];
  bit m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic cmd_t mk(bit rd, bit wr, int addr, int be, int data, int gap);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = addr[19:0]; c.be = be[1:0]; c.data = data[15:0]; c.gap = gap;
    return c;
  endfunction

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int qcount(input int q[$], input int v);
    int n = 0;
    foreach (q[i]) if (q[i] == v) n++;
    return n;
  endfunction

  task automatic fetch(input int n);
    cmd_t t;
    if (n == 0 && mq0.size() > 0) begin
      t = mq0[0];
      if (t.gap > 0) begin t.gap--; mq0[0] = t; end
      else begin cur[0] = mq0.pop_front(); cur_v[0] = 1'b1; end
    end else if (n == 1 && mq1.size() > 0) begin
      t = mq1[0];
      if (t.gap > 0) begin t.gap--; mq1[0] = t; end
      else begin cur[1] = mq1.pop_front(); cur_v[1] = 1'b1; end
    end
  endtask

  // Stimulus: inputs change 1 time unit after the rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    for (int n = 0; n < 2; n++) begin
      if (cur_v[n] && acc_seen[n]) cur_v[n] = 1'b0;
      if (!cur_v[n]) fetch(n);
    end
    bus.m0_read       = cur_v[0] & cur[0].rd;
    bus.m0_write      = cur_v[0] & cur[0].wr;
    bus.m0_address    = cur_v[0] ? cur[0].addr : '0;
    bus.m0_byteenable = cur_v[0] ? cur[0].be   : '0;
    bus.m0_writedata  = cur_v[0] ? cur[0].data : '0;
    bus.m1_read       = cur_v[1] & cur[1].rd;
    bus.m1_write      = cur_v[1] & cur[1].wr;
    bus.m1_address    = cur_v[1] ? cur[1].addr : '0;
    bus.m1_byteenable = cur_v[1] ? cur[1].be   : '0;
    bus.m1_writedata  = cur_v[1] ? cur[1].data : '0;
    bus.s_readdatavalid = 1'b0;
    bus.s_readdata      = 16'($urandom);
    if (inject_stray) begin
      inject_stray = 1'b0;
      bus.s_readdatavalid = 1'b1;
    end else if (rq.size() > 0 && rq[0] <= cyc) begin
      void'(rq.pop_front());
      bus.s_readdatavalid = 1'b1;
    end
  end

  // Monitor + reference model, sampled mid-cycle on the falling edge.
  bit mon_rd[2], mon_wr[2], mon_req[2], exp_wait[2], exp_rdv[2];
  bit exp_sr, exp_sw, mon_acc, mon_isrd, mon_stall, mon_orphan;
  int mon_o, due;
  logic [19:0] mon_addr[2];
  logic [1:0]  mon_be[2];
  logic [15:0] mon_data[2];

  always @(negedge clk) begin
    mon_rd[0] = bus.m0_read;  mon_wr[0] = bus.m0_write;
    mon_rd[1] = bus.m1_read;  mon_wr[1] = bus.m1_write;
    mon_addr[0] = bus.m0_address; mon_be[0] = bus.m0_byteenable; mon_data[0] = bus.m0_writedata;
    mon_addr[1] = bus.m1_address; mon_be[1] = bus.m1_byteenable; mon_data[1] = bus.m1_writedata;
    for (int n = 0; n < 2; n++) mon_req[n] = mon_rd[n] | mon_wr[n];

    // logs and handshake bookkeeping from observed pins
    acc_seen[0] = cur_v[0] && !bus.m0_waitrequest && !reset;
    acc_seen[1] = cur_v[1] && !bus.m1_waitrequest && !reset;
    if (first_req_c < 0 && (mon_req[0] || mon_req[1])) first_req_c = cyc;
    if (bus.s_read || bus.s_write) begin
      acc_m.push_back(bus.m0_waitrequest ? 1 : 0);
      acc_c.push_back(cyc);
      acc_addr.push_back(int'(bus.s_address));
      acc_be.push_back(int'(bus.s_byteenable));
      acc_data.push_back(int'(bus.s_writedata));
      acc_w.push_back(int'(bus.s_write));
    end
    if (bus.m0_readdatavalid) begin rdv_m.push_back(0); rdv_c.push_back(cyc); end
    if (bus.m1_readdatavalid) begin rdv_m.push_back(1); rdv_c.push_back(cyc); end
    if (bus.s_read && !reset) begin
      due = cyc + (lat_rand ? int'($urandom_range(1, 6)) : lat);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      rq.push_back(due);
    end

    if (reset) begin
      check("rst_wait0", bus.m0_waitrequest, 1);
      check("rst_wait1", bus.m1_waitrequest, 1);
      check("rst_s_read", bus.s_read, 0);
      check("rst_s_write", bus.s_write, 0);
      check("rst_rdv0", bus.m0_readdatavalid, 0);
      check("rst_rdv1", bus.m1_readdatavalid, 0);
      check("rst_err", bus.err_orphan, m_err);
      m_own = -1; m_last = 1; m_run = 0; m_idq.delete(); m_err = 1'b0;
    end else begin
      exp_wait[0] = 1'b1; exp_wait[1] = 1'b1;
      exp_sr = 1'b0; exp_sw = 1'b0; mon_acc = 1'b0; mon_isrd = 1'b0; mon_stall = 1'b0;
      mon_o = (m_own < 0) ? 0 : m_own;
      if (m_own >= 0) begin
        mon_isrd  = mon_rd[mon_o] && !mon_wr[mon_o];
        mon_stall = mon_isrd && (m_idq.size() == MAXO);
        mon_acc   = mon_req[mon_o] && !mon_stall;
        exp_wait[mon_o] = mon_stall;
        exp_sr = mon_acc && mon_isrd;
        exp_sw = mon_acc && mon_wr[mon_o];
      end
      check("wait0", bus.m0_waitrequest, exp_wait[0]);
      check("wait1", bus.m1_waitrequest, exp_wait[1]);
      check("s_read", bus.s_read, exp_sr);
      check("s_write", bus.s_write, exp_sw);
      if (mon_acc) begin
        check("s_address", bus.s_address, mon_addr[mon_o]);
        check("s_byteenable", bus.s_byteenable, mon_be[mon_o]);
        if (exp_sw) check("s_writedata", bus.s_writedata, mon_data[mon_o]);
      end

      exp_rdv[0] = 1'b0; exp_rdv[1] = 1'b0; mon_orphan = 1'b0;
      if (bus.s_readdatavalid) begin
        if (m_idq.size() == 0) mon_orphan = 1'b1;
        else exp_rdv[m_idq.pop_front()] = 1'b1;
      end
      check("rdv0", bus.m0_readdatavalid, exp_rdv[0]);
      check("rdv1", bus.m1_readdatavalid, exp_rdv[1]);
      if (exp_rdv[0]) check("readdata0", bus.m0_readdata, bus.s_readdata);
      if (exp_rdv[1]) check("readdata1", bus.m1_readdata, bus.s_readdata);
      check("err_orphan", bus.err_orphan, m_err);
      if (mon_orphan) m_err = 1'b1;
      if (mon_acc && mon_isrd) m_idq.push_back(mon_o);

      // ownership rules
      if (m_own < 0) begin
        if (mon_req[0] && mon_req[1]) m_own = 1 - m_last;
        else if (mon_req[0])          m_own = 0;
        else if (mon_req[1])          m_own = 1;
      end else if (!mon_req[mon_o]) begin
        m_last = mon_o;
        m_run  = 0;
        m_own  = mon_req[1 - mon_o] ? 1 - mon_o : -1;
      end else if (mon_acc) begin
        m_run++;
        if (m_run == HOLD_MAX) begin
          m_run = 0;
          if (mon_req[1 - mon_o]) begin
            m_last = mon_o;
            m_own  = 1 - mon_o;
          end
        end
      end
    end
  end

  function automatic bit busy();
    return (mq0.size() > 0) || (mq1.size() > 0) || cur_v[0] || cur_v[1] || (rq.size() > 0);
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy() && n < budget) begin
      @(posedge clk);
      n++;
    end
    check({name, "_timeout"}, busy(), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic clear_logs();
    acc_m.delete(); acc_c.delete(); acc_addr.delete(); acc_be.delete();
    acc_data.delete(); acc_w.delete(); rdv_m.delete(); rdv_c.delete();
    first_req_c = -1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sel;
    bus.m0_read = 0; bus.m0_write = 0; bus.m0_address = '0; bus.m0_byteenable = '0; bus.m0_writedata = '0;
    bus.m1_read = 0; bus.m1_write = 0; bus.m1_address = '0; bus.m1_byteenable = '0; bus.m1_writedata = '0;
    bus.s_readdata = '0; bus.s_readdatavalid = 1'b0;
    cur_v[0] = 0; cur_v[1] = 0; acc_seen[0] = 0; acc_seen[1] = 0;

    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2;
    check("init_wait0", bus.m0_waitrequest, 1);
    check("init_wait1", bus.m1_waitrequest, 1);
    check("init_s_read", bus.s_read, 0);
    check("init_s_write", bus.s_write, 0);
    check("init_err", bus.err_orphan, 0);

    // 1: three back-to-back reads from m0, latency 2
    clear_logs(); lat = 2; lat_rand = 0;
    for (int i = 0; i < 3; i++) mq0.push_back(mk(1, 0, 'h10 + i, 3, 0, 0));
    wait_idle("t1", 200);
    check("t1_bubble", qget(acc_c, 0) - first_req_c, 1);
    check("t1_n_accepts", acc_m.size(), 3);
    check("t1_consecutive", qget(acc_c, 2) - qget(acc_c, 0), 2);
    check("t1_first_addr", qget(acc_addr, 0), 'h10);
    check("t1_rdv_m0", qcount(rdv_m, 0), 3);
    check("t1_rdv_m1", qcount(rdv_m, 1), 0);

    // 2: both request continuously -> runs of HOLD_MAX, no gaps
    do_reset(2);
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      mq0.push_back(mk(0, 1, 'h100 + i, 3, 'h1000 + i, 0));
      mq1.push_back(mk(0, 1, 'h200 + i, 3, 'h2000 + i, 0));
    end
    wait_idle("t2", 300);
    for (int i = 0; i < 12; i++) check($sformatf("t2_owner%0d", i), qget(acc_m, i), (i / 4) % 2);
    check("t2_no_gap", qget(acc_c, 11) - qget(acc_c, 0), 11);

    // 3: FIFO full stall, latency 10
    do_reset(2);
    clear_logs(); lat = 10;
    for (int i = 0; i < 6; i++) mq0.push_back(mk(1, 0, 'h300 + i, 3, 0, 0));
    wait_idle("t3", 300);
    check("t3_first4", qget(acc_c, 3) - qget(acc_c, 0), 3);
    check("t3_fifth_after_rdv", qget(acc_c, 4), qget(rdv_c, 0) + 1);
    check("t3_rdv_count", qcount(rdv_m, 0), 6);

    // 4: interleaved outstanding reads are steered to their issuers
    clear_logs(); lat = 5;
    mq0.push_back(mk(1, 0, 'h00100, 3, 0, 0));
    mq1.push_back(mk(1, 0, 'h00200, 3, 0, 1));
    wait_idle("t4", 200);
    check("t4_n_rdv", rdv_m.size(), 2);
    check("t4_first_to_m0", qget(rdv_m, 0), 0);
    check("t4_second_to_m1", qget(rdv_m, 1), 1);
    check("t4_overlap", qget(acc_c, 1) < qget(rdv_c, 0), 1);

    // 5: m1 write at the top address with upper lane only
    clear_logs();
    mq1.push_back(mk(0, 1, 'hFFFFF, 2'b10, 'hBEEF, 0));
    wait_idle("t5", 100);
    check("t5_is_write", qget(acc_w, 0), 1);
    check("t5_owner", qget(acc_m, 0), 1);
    check("t5_addr", qget(acc_addr, 0), 'hFFFFF);
    check("t5_be", qget(acc_be, 0), 2);
    check("t5_data", qget(acc_data, 0), 'hBEEF);
    check("t5_no_rdv", rdv_m.size(), 0);

    // random traffic, random latency
    clear_logs(); lat_rand = 1;
    for (int i = 0; i < 150; i++) begin
      for (int m = 0; m < 2; m++) begin
        sel = int'($urandom_range(0, 15));
        n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
        if (m == 0) mq0.push_back(mk(sel < 8 || sel == 15, sel >= 8, int'($urandom), int'($urandom_range(0, 3)), int'($urandom), n));
        else        mq1.push_back(mk(sel < 8 || sel == 15, sel >= 8, int'($urandom), int'($urandom_range(0, 3)), int'($urandom), n));
      end
    end
    wait_idle("rand", 20000);
    check("rand_err_clear", bus.err_orphan, 0);

    // 6: reset with two reads outstanding, late returns become orphans
    lat_rand = 0; lat = 12;
    clear_logs();
    mq0.push_back(mk(1, 0, 'h400, 3, 0, 0));
    mq0.push_back(mk(1, 0, 'h401, 3, 0, 0));
    n = 0;
    while (acc_m.size() < 2 && n < 50) begin @(posedge clk); n++; end
    check("t6_two_issued", acc_m.size(), 2);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    inject_stray = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    wait_idle("t6", 100);
    check("t6_no_rdv", rdv_m.size(), 0);
    check("t6_err_orphan", bus.err_orphan, 1);
    inject_stray = 1'b1;
    repeat (2) @(posedge clk); #2;
    check("t6_err_sticky", bus.err_orphan, 1);

    do_reset(2);
    @(posedge clk); #2;
    check("t7_err_cleared", bus.err_orphan, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
